// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared widths and FSM state encoding for the multiplier-sharing arbiter
package mult_arb_pkg;
  localparam int W = 12;
  localparam int PW = 2 * W;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/mult_core.sv
// mult_core: combinational W x W -> 2W unsigned multiplier
module mult_core #(
  parameter int W = mult_arb_pkg::W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: arbitrates NREQ requesters onto one shared multiplier core
// MULT_SHARE_ARB_RR_EN selects round-robin grant; otherwise lowest index wins
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int W = mult_arb_pkg::W,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*W-1:0]  rsp_p,
  output logic [IDW-1:0]  rsp_id,
  output logic            busy
);
  import mult_arb_pkg::*;
  state_t state, nxt;
  logic [W-1:0] x_r, y_r;
  logic [2*W-1:0] prod;
  logic [IDW-1:0] g, c;
  logic any;
`ifdef MULT_SHARE_ARB_RR_EN
  logic [IDW-1:0] ptr;
`endif
  mult_core #(.W(W)) core (.a(x_r), .b(y_r), .p(prod));
  assign any = |req_valid;
  // Scan in reverse search order so the last hit is the highest-priority requester
  always_comb begin
    g = '0;
    c = '0;
`ifdef MULT_SHARE_ARB_RR_EN
    for (int k = NREQ; k >= 1; k--) begin
      c = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[c]) g = c;
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = IDW'(i);
      if (req_valid[c]) g = c;
    end
`endif
  end
  always_comb begin
    nxt = state == IDLE ? (any ? CALC : IDLE) :
          state == CALC ? RESP : (rsp_ready ? IDLE : RESP);
    req_ready = (state == IDLE && any) ? NREQ'(1) << g : '0;
    rsp_valid = state == RESP;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x_r <= '0;
      y_r <= '0;
      rsp_id <= '0;
      rsp_p <= '0;
`ifdef MULT_SHARE_ARB_RR_EN
      ptr <= IDW'(NREQ - 1);
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        x_r <= W'(req_x >> (int'(g) * W));
        y_r <= W'(req_y >> (int'(g) * W));
        rsp_id <= g;
`ifdef MULT_SHARE_ARB_RR_EN
        ptr <= g;
`endif
      end
      if (state == CALC) rsp_p <= prod;
    end
  end
endmodule
